// File: rtl/params_pkg.sv
// Shared parameters and types for the DMA stream environment.
// Holds the loopback buffer defaults and its output FSM encoding.
package params_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int KEEP_WIDTH     = DATA_WIDTH / 8;
  localparam int LOOPBACK_DEPTH = 16;

  typedef enum logic {
    IDLE,
    SEND
  } loopback_state_e;

endpackage

// File: rtl/axis_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Head entry is always visible on rd_data while not empty.
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        (do_wr && !do_rd): count <= count + CW'(1);
        (do_rd && !do_wr): count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_dma_loopback.sv
// AXI4-Stream loopback between the DMA MM2S and S2MM channels.
// Cut-through or store-and-forward release, with frame and overrun status.
module axis_dma_loopback #(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int DEPTH      = params_pkg::LOOPBACK_DEPTH,
  parameter bit STORE_FWD  = 1'b0
) (
  input  logic                      axi_aclk,
  input  logic                      axi_reset,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [15:0]               frame_count,
  output logic                      overrun
);

  import params_pkg::*;

  localparam int KW = DATA_WIDTH / 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = DATA_WIDTH + KW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  loopback_state_e state;
  loopback_state_e state_next;

  logic [BW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] occ_next;
  logic [CW-1:0] frames_in;
  logic [CW-1:0] frames_next;
  logic          push;
  logic          pop;
  logic          push_last;
  logic          pop_last;
  logic          ovr_now;
  logic          ovr_next;
  logic          rel_now;
  logic          rel_next;
  logic          ovr_set;

  assign push      = s_axis_tvalid && s_axis_tready && !fifo_full;
  assign m_axis_tvalid = (state == SEND) && !fifo_empty;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign push_last = push && s_axis_tlast;
  assign pop_last  = pop && head[BW-1];

  // Idle outputs read as zero so nothing stale leaks out of the RAM.
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} =
    m_axis_tvalid ? head : '0;

  axis_sync_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (axi_aclk),
    .reset   (axi_reset),
    .wr_en   (push),
    .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (occupancy)
  );

  always_comb begin
    occ_next    = occupancy;
    frames_next = frames_in;
    unique case (1'b1)
      (push && !pop): occ_next = occupancy + CW'(1);
      (pop && !push): occ_next = occupancy - CW'(1);
      default: ;
    endcase
    unique case (1'b1)
      (push_last && !pop_last): frames_next = frames_in + CW'(1);
      (pop_last && !push_last): frames_next = frames_in - CW'(1);
      default: ;
    endcase
  end

  // A full FIFO with no complete frame can never release otherwise.
  always_comb begin
    ovr_now  = STORE_FWD && (frames_in == '0) && (occupancy == FULL_CNT);
    ovr_next = STORE_FWD && (frames_next == '0) && (occ_next == FULL_CNT);
    if (STORE_FWD) begin
      rel_now  = (frames_in != '0) || ovr_now;
      rel_next = (frames_next != '0) || ovr_next;
    end else begin
      rel_now  = occupancy != '0;
      rel_next = occ_next != '0;
    end
  end

  always_comb begin
    state_next = state;
    ovr_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rel_now) begin
          state_next = SEND;
          ovr_set    = ovr_now;
        end
      end
      SEND: begin
        if (pop_last) begin
          if (rel_next) begin
            ovr_set = ovr_next;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      frames_in     <= '0;
      frame_count   <= '0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_next;
      s_axis_tready <= occ_next < FULL_CNT;
      frames_in     <= frames_next;
      if (pop_last) begin
        frame_count <= frame_count + 16'd1;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_dma_loopback.sv
// Directed bench for the loopback buffer: one cut-through and one
// store-and-forward instance, selected onto a shared stimulus bus.
module tb_axis_dma_loopback;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_valid;
  logic        s_last;
  logic        m_ready;

  logic        ct_s_ready, sf_s_ready;
  logic [31:0] ct_m_data, sf_m_data;
  logic [3:0]  ct_m_keep, sf_m_keep;
  logic        ct_m_valid, sf_m_valid;
  logic        ct_m_last, sf_m_last;
  logic [4:0]  ct_occ, sf_occ;
  logic [15:0] ct_fc, sf_fc;
  logic        ct_ovr, sf_ovr;

  logic        in_ready;
  logic        m_valid;
  logic [36:0] mbeat;
  logic [4:0]  occ;
  logic [15:0] fc;
  logic        ovr;

  assign in_ready = sel ? sf_s_ready : ct_s_ready;
  assign m_valid  = sel ? sf_m_valid : ct_m_valid;
  assign mbeat    = sel ? {sf_m_last, sf_m_keep, sf_m_data}
                        : {ct_m_last, ct_m_keep, ct_m_data};
  assign occ      = sel ? sf_occ : ct_occ;
  assign fc       = sel ? sf_fc : ct_fc;
  assign ovr      = sel ? sf_ovr : ct_ovr;

  always #5 clk = ~clk;

  axis_dma_loopback #(
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .STORE_FWD  (1'b0)
  ) dut_ct (
    .axi_aclk      (clk),
    .axi_reset     (rst),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tvalid (s_valid && !sel),
    .s_axis_tready (ct_s_ready),
    .s_axis_tlast  (s_last),
    .m_axis_tdata  (ct_m_data),
    .m_axis_tkeep  (ct_m_keep),
    .m_axis_tvalid (ct_m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (ct_m_last),
    .occupancy     (ct_occ),
    .frame_count   (ct_fc),
    .overrun       (ct_ovr)
  );

  axis_dma_loopback #(
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .STORE_FWD  (1'b1)
  ) dut_sf (
    .axi_aclk      (clk),
    .axi_reset     (rst),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tvalid (s_valid && sel),
    .s_axis_tready (sf_s_ready),
    .s_axis_tlast  (s_last),
    .m_axis_tdata  (sf_m_data),
    .m_axis_tkeep  (sf_m_keep),
    .m_axis_tvalid (sf_m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (sf_m_last),
    .occupancy     (sf_occ),
    .frame_count   (sf_fc),
    .overrun       (sf_ovr)
  );

  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic [3:0]  kin;
    logic        lin;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    logic [4:0]  eocc;
    logic [15:0] efc;
  } vec_t;

  vec_t        tbl[10];
  logic [36:0] rx[$];
  int          n_vec = 0;
  int          n_err = 0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      rx.push_back(mbeat);
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic offer(input int n, input logic [31:0] base,
                       input int max_cyc, input bit last_en,
                       output int acc_n);
    int   cyc;
    logic acc;
    acc_n = 0;
    cyc   = 0;
    while (acc_n < n && cyc < max_cyc) begin
      s_valid = 1'b1;
      s_data  = base + acc_n;
      s_keep  = 4'hF;
      s_last  = last_en && (acc_n == n - 1);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) acc_n++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int max_cyc);
    for (int k = 0; k < max_cyc && rx.size() < n; k++) begin
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cnt;
    int          bad;
    int          nv;
    logic [36:0] exp_b;

    tbl[0] = '{1'b1, 32'h11111111, 4'hF, 1'b0,
               1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 16'd0};
    tbl[1] = '{1'b1, 32'h22222222, 4'hF, 1'b0,
               1'b0, 32'h0, 4'h0, 1'b0, 5'd1, 16'd0};
    tbl[2] = '{1'b1, 32'h33333333, 4'hF, 1'b0,
               1'b1, 32'h11111111, 4'hF, 1'b0, 5'd2, 16'd0};
    tbl[3] = '{1'b1, 32'h44444444, 4'h3, 1'b1,
               1'b1, 32'h22222222, 4'hF, 1'b0, 5'd2, 16'd0};
    tbl[4] = '{1'b0, 32'h0, 4'h0, 1'b0,
               1'b1, 32'h33333333, 4'hF, 1'b0, 5'd2, 16'd0};
    tbl[5] = '{1'b0, 32'h0, 4'h0, 1'b0,
               1'b1, 32'h44444444, 4'h3, 1'b1, 5'd1, 16'd0};
    tbl[6] = '{1'b1, 32'hDEADBEEF, 4'h0, 1'b1,
               1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 16'd1};
    tbl[7] = '{1'b0, 32'h0, 4'h0, 1'b0,
               1'b0, 32'h0, 4'h0, 1'b0, 5'd1, 16'd1};
    tbl[8] = '{1'b0, 32'h0, 4'h0, 1'b0,
               1'b1, 32'hDEADBEEF, 4'h0, 1'b1, 5'd1, 16'd1};
    tbl[9] = '{1'b0, 32'h0, 4'h0, 1'b0,
               1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 16'd2};

    rst     = 1'b1;
    sel     = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ct", {ct_s_ready, ct_m_valid, ct_m_data, ct_m_keep,
                   ct_m_last, ct_occ, ct_fc, ct_ovr}, '0);
    chk("rst_sf", {sf_s_ready, sf_m_valid, sf_m_data, sf_m_keep,
                   sf_m_last, sf_occ, sf_fc, sf_ovr}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {ct_s_ready, sf_s_ready}, 2'b11);

    // Cut-through table.
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_valid = tbl[i].vin;
      s_data  = tbl[i].din;
      s_keep  = tbl[i].kin;
      s_last  = tbl[i].lin;
      @(negedge clk);
      chk($sformatf("ct_vec%0d", i),
          {m_valid, (m_valid ? mbeat : 37'd0), occ, fc},
          {tbl[i].ev, tbl[i].el, tbl[i].ek, tbl[i].ed,
           tbl[i].eocc, tbl[i].efc});
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    // Fill with output stalled, then stream at full rate.
    rx.delete();
    m_ready = 1'b0;
    offer(40, 32'h100, 25, 1'b0, cnt);
    chk("fill_accepted", cnt, 16);
    chk("fill_state", {in_ready, occ}, {1'b0, 5'd16});
    m_ready = 1'b1;
    fork
      offer(24, 32'h110, 200, 1'b1, cnt);
      begin
        @(negedge clk);
        chk("full_head", {m_valid, occ}, {1'b1, 5'd16});
        for (int k = 1; k <= 8; k++) begin
          @(negedge clk);
          chk($sformatf("stream_%0d", k),
              {m_valid, in_ready, occ}, {1'b1, 1'b1, 5'd15});
        end
      end
    join
    chk("rest_accepted", cnt, 24);
    wait_rx(40, 200);
    chk("fill_rx_count", rx.size(), 40);
    bad = 0;
    for (int i = 0; i < rx.size(); i++) begin
      exp_b = {(i == 39), 4'hF, 32'h100 + 32'(i)};
      if (rx[i] !== exp_b) bad++;
    end
    chk("fill_rx_order", bad, 0);
    chk("fill_fc", {fc, occ}, {16'd3, 5'd0});

    // Store-and-forward with a gap before tlast.
    sel = 1'b1;
    rx.delete();
    offer(2, 32'hA0, 10, 1'b0, cnt);
    nv = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_valid) nv++;
    end
    @(posedge clk);
    #1;
    offer(1, 32'hA2, 10, 1'b1, cnt);
    @(negedge clk);
    chk("sf_hold", {nv[7:0], m_valid, 8'(rx.size()), occ},
        {8'd0, 1'b0, 8'd0, 5'd3});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_b = {(k == 2), 4'hF, 32'hA0 + 32'(k)};
      chk($sformatf("sf_beat%0d", k), {m_valid, mbeat}, {1'b1, exp_b});
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sf_done", {m_valid, occ, fc, ovr}, {1'b0, 5'd0, 16'd1, 1'b0});
    @(posedge clk);
    #1;

    // Store-and-forward frame longer than the FIFO.
    rx.delete();
    fork
      offer(20, 32'h200, 300, 1'b1, cnt);
      begin
        nv = 0;
        do begin
          @(negedge clk);
          nv++;
        end while (!m_valid && nv < 100);
        chk("ovr_release", {m_valid, ovr, in_ready, occ},
            {1'b1, 1'b1, 1'b0, 5'd16});
      end
    join
    wait_rx(20, 200);
    chk("ovr_rx_count", rx.size(), 20);
    bad = 0;
    for (int i = 0; i < rx.size(); i++) begin
      exp_b = {(i == 19), 4'hF, 32'h200 + 32'(i)};
      if (rx[i] !== exp_b) bad++;
    end
    chk("ovr_rx_order", bad, 0);
    chk("ovr_status", {fc, ovr, occ}, {16'd2, 1'b1, 5'd0});

    // Reset with a partial frame stored.
    sel     = 1'b0;
    m_ready = 1'b0;
    offer(5, 32'h300, 20, 1'b0, cnt);
    chk("pre_rst_occ", occ, 5'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst", {m_valid, in_ready, occ, fc}, '0);
    chk("mid_rst_sf", {sf_occ, sf_fc, sf_ovr}, '0);
    @(posedge clk);
    #1;
    rx.delete();
    m_ready = 1'b1;
    offer(2, 32'h400, 20, 1'b1, cnt);
    wait_rx(2, 20);
    chk("post_rst_count", rx.size(), 2);
    if (rx.size() == 2) begin
      chk("post_rst_beats", {rx[0], rx[1]},
          {1'b0, 4'hF, 32'h400, 1'b1, 4'hF, 32'h401});
    end
    chk("post_rst_status", {occ, fc, m_valid}, {5'd0, 16'd1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
